// File: rtl/vga_mode_transition_ctrl.sv
// vga_mode_transition_ctrl: defers page/mode switches to frame boundaries and wraps each one in
// a fade-out, one blank frame with the renderers held in reset, and a fade-in.
module vga_mode_transition_ctrl #(
    parameter logic [7:0] RESET_MODE      = 8'h00,
    parameter int         FADE_SHIFT      = 3,
    parameter int         FRAMES_PER_STEP = 2
) (
    input  logic        vga_clk,
    input  logic        rst_n,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic [7:0]  req_mode,
    input  logic [23:0] pix_in,
    output logic [7:0]  active_mode,
    output logic        renderer_rst_n,
    output logic [23:0] pix_out,
    output logic        busy
);
    localparam int LW = FADE_SHIFT + 1;
    localparam int SW = FRAMES_PER_STEP > 1 ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int PW = 9 + FADE_SHIFT;
    localparam logic [LW-1:0] LMAX = LW'(1) << FADE_SHIFT;

    typedef enum logic [1:0] {IDLE, FADE_OUT, SWITCH, FADE_IN} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] level_q, level_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d, step_nx;
    logic [7:0]    active_mode_q, active_mode_d, target_q, target_d;
    logic [23:0]   pix_out_q, pix_d;
    logic          frame_start, tick;

    assign frame_start = (pos_x == '0) && (pos_y == '0);
    assign tick        = step_cnt_q == SW'(FRAMES_PER_STEP - 1);
    assign step_nx     = tick ? '0 : step_cnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        step_cnt_d    = step_cnt_q;
        active_mode_d = active_mode_q;
        target_d      = target_q;
        case (state_q)
            IDLE: if (frame_start && req_mode != active_mode_q) begin
                target_d   = req_mode;
                state_d    = FADE_OUT;
                step_cnt_d = '0;
            end
            FADE_OUT: begin
                target_d = req_mode;
                if (frame_start) begin
                    if (req_mode == active_mode_q) begin
                        state_d    = FADE_IN;
                        step_cnt_d = '0;
                    end else begin
                        step_cnt_d = step_nx;
                        if (tick) begin
                            level_d = (level_q == '0) ? '0 : level_q - 1'b1;
                            // the tick that reaches zero also commits the latest request
                            if (level_q <= LW'(1)) begin
                                state_d       = SWITCH;
                                step_cnt_d    = '0;
                                active_mode_d = target_d;
                            end
                        end
                    end
                end
            end
            SWITCH: begin
                level_d = '0;
                if (frame_start) begin
                    state_d    = FADE_IN;
                    step_cnt_d = '0;
                end
            end
            FADE_IN: if (frame_start) begin
                if (req_mode != active_mode_q) begin
                    target_d   = req_mode;
                    state_d    = FADE_OUT;
                    step_cnt_d = '0;
                end else begin
                    step_cnt_d = step_nx;
                    if (tick) begin
                        level_d = level_q + 1'b1;
                        if (level_q == LMAX - 1'b1) begin
                            state_d    = IDLE;
                            step_cnt_d = '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar c = 0; c < 3; c++) begin : g_ch
        assign pix_d[8*c+:8] = 8'((PW'(pix_in[8*c+:8]) * PW'(level_q)) >> FADE_SHIFT);
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            level_q       <= LMAX;
            step_cnt_q    <= '0;
            active_mode_q <= RESET_MODE;
            target_q      <= RESET_MODE;
            pix_out_q     <= '0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            step_cnt_q    <= step_cnt_d;
            active_mode_q <= active_mode_d;
            target_q      <= target_d;
            pix_out_q     <= pix_d;
        end
    end

    assign active_mode    = active_mode_q;
    assign renderer_rst_n = state_q != SWITCH;
    assign busy           = state_q != IDLE;
    assign pix_out        = pix_out_q;
endmodule

// File: tb/tb_vga_mode_transition_ctrl.sv
// tb_vga_mode_transition_ctrl: directed vectors on a shrunken 4x2 frame, default and 1-bit/1-frame instances.
module tb_vga_mode_transition_ctrl;
    typedef struct {
        logic       six;
        logic [7:0] req;
        logic [23:0] pix;
        logic [7:0] mode;
        logic       busy;
        logic       rrst;
        logic [23:0] pout;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [9:0]  pos_x = '0, pos_y = '0;
    logic [7:0]  req = '0, req6 = '0;
    logic [23:0] pix = 24'hFFFFFF, pix6 = 24'hFF00FF;
    logic [7:0]  mode, mode6;
    logic        rrst, rrst6, busy, busy6;
    logic [23:0] pout, pout6;
    int checks = 0, errors = 0;
    vec_t v[$];

    vga_mode_transition_ctrl dut (
        .vga_clk(clk), .rst_n(rst_n), .pos_x(pos_x), .pos_y(pos_y), .req_mode(req), .pix_in(pix),
        .active_mode(mode), .renderer_rst_n(rrst), .pix_out(pout), .busy(busy)
    );
    vga_mode_transition_ctrl #(.RESET_MODE(8'h00), .FADE_SHIFT(1), .FRAMES_PER_STEP(1)) dut6 (
        .vga_clk(clk), .rst_n(rst_n), .pos_x(pos_x), .pos_y(pos_y), .req_mode(req6), .pix_in(pix6),
        .active_mode(mode6), .renderer_rst_n(rrst6), .pix_out(pout6), .busy(busy6)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pos_x == 10'd3) begin
            pos_x = '0;
            pos_y = pos_y ^ 10'd1;
        end else pos_x = pos_x + 10'd1;
    endtask

    // ends one pixel past the frame start, so pix_out already reflects the new level
    task automatic frame();
        while (!(pos_x == '0 && pos_y == '0)) tick();
        tick();
        tick();
    endtask

    task automatic run(input vec_t e, input string nm);
        if (e.six) req6 = e.req; else begin req = e.req; pix = e.pix; end
        frame();
        chk({nm, " mode"}, e.six ? mode6 : mode, e.mode);
        chk({nm, " busy"}, e.six ? busy6 : busy, e.busy);
        chk({nm, " rrst"}, e.six ? rrst6 : rrst, e.rrst);
        chk({nm, " pix"},  e.six ? pout6 : pout, e.pout);
    endtask

    function automatic logic [23:0] lv(input int l);
        logic [7:0] b;
        b = 8'(16 * l);
        return {b, b, b};
    endfunction

    initial begin
        // fade out/in 00 -> 01 on 808080, frames numbered from the frame start that raises busy
        for (int n = 0; n <= 35; n++) begin
            vec_t e;
            e.six = 0; e.req = 8'h01; e.pix = 24'h808080; e.rrst = 1; e.busy = 1;
            if (n <= 16) begin
                e.pout = lv(8 - n / 2); e.mode = (n == 16) ? 8'h01 : 8'h00; e.rrst = (n != 16);
            end else begin
                e.pout = lv(n >= 33 ? 8 : (n - 17) / 2); e.mode = 8'h01; e.busy = (n < 33);
            end
            v.push_back(e);
        end
        v.push_back('{1, 8'h01, 24'h0, 8'h00, 1, 1, 24'hFF00FF});
        v.push_back('{1, 8'h01, 24'h0, 8'h00, 1, 1, 24'h7F007F});
        v.push_back('{1, 8'h01, 24'h0, 8'h01, 1, 0, 24'h000000});
        v.push_back('{1, 8'h01, 24'h0, 8'h01, 1, 1, 24'h000000});
        v.push_back('{1, 8'h01, 24'h0, 8'h01, 1, 1, 24'h7F007F});
        v.push_back('{1, 8'h01, 24'h0, 8'h01, 0, 1, 24'hFF00FF});

        tick();
        tick();
        chk("reset mode", mode, 8'h00);
        chk("reset busy", busy, 1'b0);
        chk("reset rrst", rrst, 1'b1);
        chk("reset pix", pout, 24'h0);
        chk("reset pix6", pout6, 24'h0);
        rst_n = 1'b1;

        for (int f = 0; f < 3; f++) begin
            frame();
            chk("idle mode", mode, 8'h00);
            chk("idle busy", busy, 1'b0);
            chk("idle pix", pout, 24'hFFFFFF);
        end
        pix = 24'h123456;
        tick();
        chk("pix latency", pout, 24'h123456);

        req = 8'h01;
        tick();
        chk("midframe busy", busy, 1'b0);
        for (int i = 0; i < 36; i++) run(v[i], $sformatf("switch f%0d", i));

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 8'h01;
        pix = 24'h808080;
        for (int n = 0; n <= 16; n++) begin
            if (n == 7) req = 8'h02;
            frame();
            chk($sformatf("retarget pix f%0d", n), pout, lv(8 - n / 2));
            chk($sformatf("retarget mode f%0d", n), mode, n == 16 ? 8'h02 : 8'h00);
        end
        chk("switch rrst", rrst, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("async mode", mode, 8'h00);
        chk("async rrst", rrst, 1'b1);
        chk("async pix", pout, 24'h0);
        chk("async busy", busy, 1'b0);
        tick();
        rst_n = 1'b1;

        req = 8'h01;
        for (int n = 0; n <= 10; n++) frame();
        chk("withdraw start pix", pout, lv(3));
        req = 8'h00;
        for (int m = 0; m <= 10; m++) begin
            frame();
            chk($sformatf("withdraw pix f%0d", m), pout, lv(3 + m / 2));
            chk($sformatf("withdraw busy f%0d", m), busy, m != 10);
            chk($sformatf("withdraw rrst f%0d", m), rrst, 1'b1);
            chk($sformatf("withdraw mode f%0d", m), mode, 8'h00);
        end

        for (int i = 36; i < v.size(); i++) run(v[i], $sformatf("fast f%0d", i - 36));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
